// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_resp responder.
// Optional build macro MEM_RAND_DELAY_EN uses the LFSR helpers defined here.
package mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LAT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } port_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic              wen;
        logic [WORD_W-1:0] wdata;
        logic [3:0]        wmask;
    } lsu_req_t;

    localparam logic [WORD_W-1:0] MEM_OOR_DATA  = 32'hDEAD_BEEF;
    localparam logic [7:0]        MEM_LFSR_SEED = 8'hA5;

    // Fibonacci LFSR step, taps 8,6,5,4
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/mem_resp_if.sv
// Core-to-memory request/response bundle for the fetch and load/store ports.
interface mem_resp_if;
    logic        io_ifu_reqValid;
    logic [31:0] io_ifu_addr;
    logic        io_ifu_respValid;
    logic [31:0] io_ifu_rdata;
    logic        io_lsu_reqValid;
    logic [31:0] io_lsu_addr;
    logic [1:0]  io_lsu_size;
    logic        io_lsu_wen;
    logic [31:0] io_lsu_wdata;
    logic [3:0]  io_lsu_wmask;
    logic        io_lsu_respValid;
    logic [31:0] io_lsu_rdata;

    modport master (
        output io_ifu_reqValid, io_ifu_addr,
        input  io_ifu_respValid, io_ifu_rdata,
        output io_lsu_reqValid, io_lsu_addr, io_lsu_size, io_lsu_wen, io_lsu_wdata, io_lsu_wmask,
        input  io_lsu_respValid, io_lsu_rdata
    );

    modport slave (
        input  io_ifu_reqValid, io_ifu_addr,
        output io_ifu_respValid, io_ifu_rdata,
        input  io_lsu_reqValid, io_lsu_addr, io_lsu_size, io_lsu_wen, io_lsu_wdata, io_lsu_wmask,
        output io_lsu_respValid, io_lsu_rdata
    );
endinterface

// File: rtl/mem_port_fsm.sv
// Per-port IDLE/WAIT/RESP sequencer: latency counter, read-data register, response pulse.
module mem_port_fsm
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept_c,
    input  logic [LAT_W-1:0]  lat,
    input  logic [WORD_W-1:0] load_data,
    output logic              idle_c,
    output logic              resp_valid,
    output logic [WORD_W-1:0] rdata
);

    port_state_e       state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    rdata_d = load_data;
                    cnt_d   = lat - LAT_W'(1);
                    state_d = (lat == LAT_W'(1)) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - LAT_W'(1);
                if (cnt_q == LAT_W'(1)) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign idle_c     = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;

endmodule

// File: rtl/mem_resp.sv
// Word-addressed RAM responder for the core's fetch and load/store ports, LSU has priority.
// Build macro MEM_RAND_DELAY_EN adds an LFSR-driven 0..3 cycle extra latency per request.
module mem_resp
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input logic       clock,
    input logic       reset,
    mem_resp_if.slave io
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

    logic              ifu_idle_c, lsu_idle_c, ifu_acc_c, lsu_acc_c, in_range_c;
    logic [31:0]       acc_addr_c, offset_c, rd_word_c, lsu_load_c;
    logic [IDX_W-1:0]  idx_c;
    logic [LAT_W-1:0]  lat_c;
    lsu_req_t          lsu_c;
    logic              unused_c;
    logic [31:0]       mem_q [DEPTH_WORDS];

    // Arbitration, shared decode and single array read port
    always_comb begin
        lsu_c      = '{addr: io.io_lsu_addr, wen: io.io_lsu_wen,
                       wdata: io.io_lsu_wdata, wmask: io.io_lsu_wmask};
        lsu_acc_c  = io.io_lsu_reqValid & lsu_idle_c;
        ifu_acc_c  = io.io_ifu_reqValid & ifu_idle_c & ~lsu_acc_c;
        acc_addr_c = lsu_acc_c ? lsu_c.addr : io.io_ifu_addr;
        offset_c   = acc_addr_c - BASE_ADDR;
        in_range_c = (offset_c < SPAN);
        idx_c      = offset_c[IDX_W+1:2];
        rd_word_c  = in_range_c ? mem_q[idx_c] : MEM_OOR_DATA;
        lsu_load_c = lsu_c.wen ? '0 : rd_word_c;
    end

    assign unused_c = ^{io.io_lsu_size, offset_c[1:0]};

    // Array contents survive reset, so no reset branch here
    always_ff @(posedge clock) begin
        if (lsu_acc_c && lsu_c.wen && in_range_c) begin
            for (int i = 0; i < 4; i++) begin
                if (lsu_c.wmask[i]) mem_q[idx_c][8*i +: 8] <= lsu_c.wdata[8*i +: 8];
            end
        end
    end

`ifdef MEM_RAND_DELAY_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (ifu_acc_c || lsu_acc_c) lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) lfsr_q <= MEM_LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign lat_c = LAT_W'(LATENCY) + LAT_W'(lfsr_q[1:0]);
`else
    assign lat_c = LAT_W'(LATENCY);
`endif

    mem_port_fsm u_ifu (
        .clk        (clock),
        .rst_n      (reset),
        .accept_c   (ifu_acc_c),
        .lat        (lat_c),
        .load_data  (rd_word_c),
        .idle_c     (ifu_idle_c),
        .resp_valid (io.io_ifu_respValid),
        .rdata      (io.io_ifu_rdata)
    );

    mem_port_fsm u_lsu (
        .clk        (clock),
        .rst_n      (reset),
        .accept_c   (lsu_acc_c),
        .lat        (lat_c),
        .load_data  (lsu_load_c),
        .idle_c     (lsu_idle_c),
        .resp_valid (io.io_lsu_respValid),
        .rdata      (io.io_lsu_rdata)
    );

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp: one instance at LATENCY=1, one at LATENCY=4.
module tb_mem_resp;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned DEPTH = 256;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    mem_resp_if bus1 ();
    mem_resp_if bus4 ();

    mem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
        .clock (clock), .reset (reset), .io (bus1)
    );
    mem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(4)) dut4 (
        .clock (clock), .reset (reset), .io (bus4)
    );

`ifdef MEM_RAND_DELAY_EN
    logic [7:0] lf1 = 8'hA5;
    logic [7:0] lf4 = 8'hA5;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected latency of the next acceptance on a DUT; advances the LFSR model
    task automatic model_accept(input bit s4, output int lat);
`ifdef MEM_RAND_DELAY_EN
        if (s4) begin
            lat = 4 + int'(lf4[1:0]);
            lf4 = {lf4[6:0], lf4[7] ^ lf4[5] ^ lf4[4] ^ lf4[3]};
        end else begin
            lat = 1 + int'(lf1[1:0]);
            lf1 = {lf1[6:0], lf1[7] ^ lf1[5] ^ lf1[4] ^ lf1[3]};
        end
`else
        lat = s4 ? 4 : 1;
`endif
    endtask

    task automatic model_reset();
`ifdef MEM_RAND_DELAY_EN
        lf1 = 8'hA5;
        lf4 = 8'hA5;
`endif
    endtask

    task automatic drive(input bit s4, input bit p, input bit v, input logic [31:0] a,
                         input bit w, input logic [31:0] d, input logic [3:0] m);
        if (!s4 && !p) begin
            bus1.io_ifu_reqValid = v; bus1.io_ifu_addr = a;
        end else if (!s4) begin
            bus1.io_lsu_reqValid = v; bus1.io_lsu_addr = a;
            bus1.io_lsu_wen = w; bus1.io_lsu_wdata = d; bus1.io_lsu_wmask = m;
        end else if (!p) begin
            bus4.io_ifu_reqValid = v; bus4.io_ifu_addr = a;
        end else begin
            bus4.io_lsu_reqValid = v; bus4.io_lsu_addr = a;
            bus4.io_lsu_wen = w; bus4.io_lsu_wdata = d; bus4.io_lsu_wmask = m;
        end
    endtask

    function automatic logic get_rv(input bit s4, input bit p);
        if (s4) return p ? bus4.io_lsu_respValid : bus4.io_ifu_respValid;
        return p ? bus1.io_lsu_respValid : bus1.io_ifu_respValid;
    endfunction

    function automatic logic [31:0] get_rd(input bit s4, input bit p);
        if (s4) return p ? bus4.io_lsu_rdata : bus4.io_ifu_rdata;
        return p ? bus1.io_lsu_rdata : bus1.io_ifu_rdata;
    endfunction

    // One request on an idle port; checks latency and single-cycle pulse
    task automatic txn(input string tag, input bit s4, input bit p, input logic [31:0] a,
                       input bit w, input logic [31:0] d, input logic [3:0] m,
                       output logic [31:0] rd);
        int lat;
        int exp_l;
        @(posedge clock); #1;
        drive(s4, p, 1'b1, a, w, d, m);
        model_accept(s4, exp_l);
        @(posedge clock);
        for (lat = 1; lat <= 40; lat++) begin
            @(negedge clock);
            if (get_rv(s4, p)) break;
            @(posedge clock);
        end
        rd = get_rd(s4, p);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_l));
        drive(s4, p, 1'b0, a, w, d, m);
        @(negedge clock);
        chk({tag, "_pulse"}, {31'd0, get_rv(s4, p)}, 32'd0);
    endtask

    logic [31:0] rd;
    logic [31:0] rd_a, rd_b;
    int          seen, la, lb, ca, cb;

    initial begin
        bus1.io_lsu_size = 2'b10;
        bus4.io_lsu_size = 2'b10;
        drive(0, 0, 0, '0, 0, '0, '0); drive(0, 1, 0, '0, 0, '0, '0);
        drive(1, 0, 0, '0, 0, '0, '0); drive(1, 1, 0, '0, 0, '0, '0);

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_rv1", {30'd0, bus1.io_ifu_respValid, bus1.io_lsu_respValid}, 32'd0);
        chk("rst_rv4", {30'd0, bus4.io_ifu_respValid, bus4.io_lsu_respValid}, 32'd0);
        chk("rst_rd1", bus1.io_ifu_rdata | bus1.io_lsu_rdata, 32'd0);
        chk("rst_rd4", bus4.io_ifu_rdata | bus4.io_lsu_rdata, 32'd0);
        @(posedge clock); #1 reset = 1'b1;

        // Reset in the middle of a LATENCY=4 wait aborts the response
        @(posedge clock); #1;
        drive(1, 1, 1, BASE + 32'd8, 0, '0, '0);
        model_accept(1, la);
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        drive(1, 1, 0, BASE + 32'd8, 0, '0, '0);
        seen = 0;
        repeat (3) begin
            @(negedge clock);
            seen += int'(bus4.io_lsu_respValid);
        end
        chk("rst_mid_rd", bus4.io_lsu_rdata, 32'd0);
        @(posedge clock); #1 reset = 1'b1;
        repeat (10) begin
            @(negedge clock);
            seen += int'(bus4.io_lsu_respValid);
        end
        chk("rst_no_resp", 32'(seen), 32'd0);
        chk("rst_after_rd", bus4.io_lsu_rdata, 32'd0);

        // Full-word store/load, LATENCY=4
        txn("st4", 1, 1, BASE + 32'd8, 1, 32'h1122_3344, 4'b1111, rd);
        chk("st4_rd", rd, 32'd0);
        txn("ld4", 1, 1, BASE + 32'd8, 0, '0, '0, rd);
        chk("ld4_rd", rd, 32'h1122_3344);

        // Byte-lane merge, mask 0 store, addr[1:0] ignored, LATENCY=1
        txn("stff", 0, 1, BASE + 32'h10, 1, 32'hFFFF_FFFF, 4'b1111, rd);
        txn("stlane", 0, 1, BASE + 32'h10, 1, 32'h0000_AB00, 4'b0010, rd);
        txn("ldlane", 0, 1, BASE + 32'h10, 0, '0, '0, rd);
        chk("ldlane_rd", rd, 32'hFFFF_ABFF);
        txn("stm0", 0, 1, BASE + 32'h10, 1, 32'h1234_5678, 4'b0000, rd);
        chk("stm0_rd", rd, 32'd0);
        txn("ldm0", 0, 1, BASE + 32'h13, 0, '0, '0, rd);
        chk("ldm0_rd", rd, 32'hFFFF_ABFF);
        txn("fetch", 0, 0, BASE + 32'h10, 0, '0, '0, rd);
        chk("fetch_rd", rd, 32'hFFFF_ABFF);

        // Out-of-range: reads give DEADBEEF, writes do not alias into the array
        txn("st_w0", 0, 1, BASE, 1, 32'hA5A5_A5A5, 4'b1111, rd);
        txn("st_wl", 0, 1, BASE + 32'(DEPTH*4 - 4), 1, 32'h0BAD_F00D, 4'b1111, rd);
        txn("st_hi", 0, 1, BASE + 32'(DEPTH*4), 1, 32'hCAFE_0001, 4'b1111, rd);
        txn("st_lo", 0, 1, BASE - 32'd4, 1, 32'hCAFE_0002, 4'b1111, rd);
        txn("ld_lo", 0, 1, BASE - 32'd4, 0, '0, '0, rd);
        chk("ld_lo_rd", rd, 32'hDEAD_BEEF);
        txn("ld_hi", 0, 1, BASE + 32'(DEPTH*4), 0, '0, '0, rd);
        chk("ld_hi_rd", rd, 32'hDEAD_BEEF);
        txn("ld_w0", 0, 1, BASE, 0, '0, '0, rd);
        chk("ld_w0_rd", rd, 32'hA5A5_A5A5);
        txn("ld_wl", 0, 0, BASE + 32'(DEPTH*4 - 4), 0, '0, '0, rd);
        chk("ld_wl_rd", rd, 32'h0BAD_F00D);

        // Same-cycle store and fetch to one word: LSU first, fetch sees new data
        @(posedge clock); #1;
        drive(0, 1, 1, BASE + 32'h20, 1, 32'h5566_7788, 4'b1111);
        drive(0, 0, 1, BASE + 32'h20, 0, '0, '0);
        model_accept(0, la);
        model_accept(0, lb);
        @(posedge clock);
        ca = 0; cb = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (ca == 0 && bus1.io_lsu_respValid) begin
                ca = c; rd_a = bus1.io_lsu_rdata; drive(0, 1, 0, '0, 0, '0, '0);
            end
            if (cb == 0 && bus1.io_ifu_respValid) begin
                cb = c; rd_b = bus1.io_ifu_rdata; drive(0, 0, 0, '0, 0, '0, '0);
            end
            if (ca != 0 && cb != 0) break;
            @(posedge clock);
        end
        chk("col_lsu_at", 32'(ca), 32'(la));
        chk("col_ifu_at", 32'(cb), 32'(1 + lb));
        chk("col_lsu_rd", rd_a, 32'd0);
        chk("col_ifu_rd", rd_b, 32'h5566_7788);

        // Request held across two transactions: no acceptance during RESP
        @(posedge clock); #1;
        drive(0, 0, 1, BASE + 32'h10, 0, '0, '0);
        model_accept(0, la);
        model_accept(0, lb);
        @(posedge clock);
        ca = 0; cb = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            if (bus1.io_ifu_respValid) begin
                if (ca == 0) begin
                    ca = c; rd_a = bus1.io_ifu_rdata;
                end else begin
                    cb = c; rd_b = bus1.io_ifu_rdata; drive(0, 0, 0, '0, 0, '0, '0);
                    break;
                end
            end
            @(posedge clock);
        end
        chk("b2b_first", 32'(ca), 32'(la));
        chk("b2b_second", 32'(cb), 32'(la + 1 + lb));
        chk("b2b_rd", rd_a & rd_b, 32'hFFFF_ABFF);
        @(negedge clock);

`ifdef MEM_RAND_DELAY_EN
        for (int i = 0; i < 200; i++) begin
            txn("rnd", 0, 0, BASE + 32'(4 * (i % 8)), 0, '0, '0, rd);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_resp.md
# mem_resp

Memory-side responder for the core's two request/response ports (instruction fetch and load/store). Holds a word-addressed RAM array, accepts one outstanding request per port, serialises array access between ports, and returns a single-cycle `respValid` pulse after a programmable latency. Sits at SoC level directly opposite the core: every `reqValid`/`addr`/`wen`/`wdata`/`wmask` the core drives lands here.

## Interface
Parameters:
- `DEPTH_WORDS`, 4096: array depth in 32-bit words (power of two).
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0.
- `LATENCY`, 1: cycles from request acceptance to `respValid`; legal range 1..15.

Ports:
- `clock`  input  1  sole clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `io_ifu_reqValid`  input  1  fetch request pending.
- `io_ifu_addr`  input  32  fetch byte address.
- `io_ifu_respValid`  output  1  fetch response pulse.
- `io_ifu_rdata`  output  32  fetch word.
- `io_lsu_reqValid`  input  1  load/store request pending.
- `io_lsu_addr`  input  32  load/store byte address.
- `io_lsu_size`  input  2  access size; ignored (lanes handled by the core).
- `io_lsu_wen`  input  1  1 = store, 0 = load.
- `io_lsu_wdata`  input  32  store data, already lane-aligned.
- `io_lsu_wmask`  input  4  byte-enable, bit i = byte lane i.
- `io_lsu_respValid`  output  1  load/store response pulse.
- `io_lsu_rdata`  output  32  load word (full word; core extracts lanes).

## Operation
- Per-port FSM, states IDLE → WAIT → RESP → IDLE.
- IDLE: port accepted on a rising edge where `reqValid`=1 and port wins arbitration; request captured, array accessed on that same edge, counter loaded with latency−1.
- Arbitration: both ports requesting in IDLE in same cycle → LSU accepted, IFU stays IDLE and is accepted next eligible cycle. Only one array access per cycle.
- WAIT: counter decrements each cycle; at 0 go to RESP. LATENCY=1 skips WAIT.
- RESP: `respValid`=1 for exactly one cycle, then IDLE. No acceptance in RESP cycle on that port; next request accepted earliest the following edge.
- Index = (addr − BASE_ADDR) >> 2; `addr[1:0]` ignored. In range iff `addr − BASE_ADDR` < DEPTH_WORDS*4 (unsigned).
- Store: per-lane write of lanes with `wmask` bit set; `wmask`=0 writes nothing; response still given, `rdata`=0.
- Load/fetch: word read into port's rdata register at acceptance.
- Out-of-range: writes dropped, reads return 32'hDEAD_BEEF; response timing unchanged.
- Initiator holds inputs stable from `reqValid` rise until `respValid`; responder samples only at acceptance.

## Timing
- Reset (`reset`=0, async): both FSMs IDLE, `respValid`=0, `rdata`=0, counters 0. Array contents not cleared. Reset mid-transaction aborts it; no response later issued.
- Accepted at edge T → `respValid` high in cycle T+LATENCY (LATENCY=1: the cycle after acceptance).
- Back-to-back same port: minimum LATENCY+1 cycles per transaction.
- `rdata` valid while `respValid`=1; holds last value otherwise.
- Store then fetch to same word: fetch accepted after store edge returns new data; same-cycle collision resolved by LSU priority, so fetch sees new data.

## Configuration
- `MEM_RAND_DELAY_EN` defined: 8-bit Fibonacci LFSR (taps 8,6,5,4), reset seed 8'hA5, advances on every acceptance; accepted request's latency = LATENCY + lfsr[1:0] (1..18 cycles). Arbitration and data behaviour unchanged.
- Undefined: fixed LATENCY, no LFSR logic.

## Structure
- Shared package `mem_pkg`: port-state enum (IDLE/WAIT/RESP), `MEM_OOR_DATA` = 32'hDEAD_BEEF, LFSR seed constant.
- One sub-module `mem_port_fsm` (state, counter, rdata register, `respValid`), instantiated twice; array, address decode and arbiter in the top.

## Test plan
- Reset mid-WAIT with LATENCY=4 → `respValid` never pulses, outputs 0 during and after reset.
- LSU store 32'h1122_3344 mask 4'b1111 to BASE_ADDR+8, then load → `rdata`=32'h1122_3344, `respValid` exactly LATENCY cycles after each acceptance.
- Store 32'h0000_AB00 mask 4'b0010 over 32'hFFFF_FFFF → load returns 32'hFFFF_ABFF.
- Simultaneous IFU fetch and LSU store to same word, LATENCY=1 → LSU `respValid` at T+1, IFU at T+2 with stored data.
- Load from BASE_ADDR−4 and BASE_ADDR+DEPTH_WORDS*4 → 32'hDEAD_BEEF, array unchanged.
- `MEM_RAND_DELAY_EN` build, 200 random fetches → every latency in LATENCY..LATENCY+3, sequence matches LFSR model from seed 8'hA5.
